// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: sequences one load/store between the execute stage and a
// 64-bit data memory. It captures the access on start and then runs a
// request/acknowledge handshake with the memory. Upstream is stalled until
// the memory acks or a timeout expires. The block also does byte-lane
// steering for stores and sign/zero extension for loads.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - a naturally misaligned access goes straight to ERR at start
//               and never raises mem_req.
//   undefined - a misaligned access is issued as-is; lanes past 7 are dropped.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; stall follows start combinationally
// REQ   | mem_req held, counting cycles toward TIMEOUT
// DONE  | one-cycle done pulse, start ignored
// ERR   | one-cycle err pulse (timeout or trapped misalignment)

module lsu_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic        done,
    output logic [63:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Counter value on the last REQ cycle that may still accept an ack.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [2:0]  off_q;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [7:0]  mem_be_q;
    logic [63:0] mem_wdata_q;
    logic        done_q;
    logic        err_q;
    logic [63:0] rdata_q;

    logic [7:0]  base_be;
    logic [63:0] wmask;
    logic [7:0]  in_be;
    logic [63:0] in_wdata;
    logic        misaligned;
    logic [63:0] rd_shift;
    logic [63:0] ld_ext;

    // Byte enables, store data steering and alignment check for the incoming access.
    always_comb begin
        base_be    = 8'h01;
        wmask      = 64'h0000_0000_0000_00FF;
        misaligned = 1'b0;
        case (size)
            2'b00: begin
                base_be    = 8'h01;
                wmask      = 64'h0000_0000_0000_00FF;
                misaligned = 1'b0;
            end
            2'b01: begin
                base_be    = 8'h03;
                wmask      = 64'h0000_0000_0000_FFFF;
                misaligned = addr[0];
            end
            2'b10: begin
                base_be    = 8'h0F;
                wmask      = 64'h0000_0000_FFFF_FFFF;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: begin
                base_be    = 8'hFF;
                wmask      = 64'hFFFF_FFFF_FFFF_FFFF;
                misaligned = (addr[2:0] != 3'b000);
            end
        endcase
        in_be    = base_be << addr[2:0];
        in_wdata = (wdata & wmask) << {addr[2:0], 3'b000};
    end

    // Right-align the raw doubleword and extend it according to the captured size.
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        ld_ext   = rd_shift;
        case (size_q)
            2'b00:   ld_ext = uns_q ? {56'd0, rd_shift[7:0]}
                                    : {{56{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_ext = uns_q ? {48'd0, rd_shift[15:0]}
                                    : {{48{rd_shift[15]}}, rd_shift[15:0]};
            2'b10:   ld_ext = uns_q ? {32'd0, rd_shift[31:0]}
                                    : {{32{rd_shift[31]}}, rd_shift[31:0]};
            default: ld_ext = rd_shift;
        endcase
    end

    // Next-state, wait counter and combinational stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    cnt_d = 8'd0;
`ifdef MISALIGN_TRAP_EN
                    state_d = misaligned ? S_ERR : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                // An ack on the final counted cycle still completes normally.
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, registered outputs and captured access fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_be_q    <= 8'd0;
            mem_wdata_q <= 64'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= (state_d == S_REQ);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
            if (state_q == S_IDLE && state_d == S_REQ) begin
                store_q     <= is_store;
                size_q      <= size;
                uns_q       <= unsigned_ld;
                off_q       <= addr[2:0];
                mem_we_q    <= is_store;
                mem_addr_q  <= {addr[63:3], 3'b000};
                mem_be_q    <= in_be;
                mem_wdata_q <= in_wdata;
            end
            if (state_q == S_REQ && mem_ack && !store_q) begin
                rdata_q <= ld_ext;
            end
        end
    end

    // The misalignment flag only steers the FSM when the trap is built in.
    logic unused_misaligned;
    assign unused_misaligned = misaligned;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: directed cases followed by randomized accesses,
// compared against a byte-level reference model of lane steering and extension.
module tb_lsu_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset, start, is_store, unsigned_ld, mem_ack;
    logic [1:0]  size;
    logic [63:0] addr, wdata, mem_rdata;
    logic        mem_req, mem_we, stall, done, err;
    logic [63:0] mem_addr, mem_wdata, rdata;
    logic [7:0]  mem_be;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_rdata;

    lsu_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .done(done), .rdata(rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] m_be(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] be = 8'd0;
        for (int i = 0; i < (1 << sz); i++)
            if (int'(off) + i < 8) be[int'(off) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [1:0] sz, input logic [2:0] off,
                                            input logic [63:0] wd);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < (1 << sz); i++)
            if (int'(off) + i < 8) r[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [1:0] sz, input logic [2:0] off,
                                           input logic un, input logic [63:0] raw);
        logic [63:0] v = 64'd0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = raw[8*(int'(off)+i) +: 8];
        if (n < 8 && !un && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [2:0] off);
        return (int'(off) % (1 << sz)) != 0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One access; ack_at is the REQ cycle index carrying the ack (>= TO means never).
    task automatic access(input logic st, input logic [1:0] sz, input logic un,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input int ack_at, input bit poke_done);
        bit acked = 1'b0;
        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; unsigned_ld = un; addr = a; wdata = wd;
        mem_ack = 1'b0;
        #1 chk("stall_start", {63'd0, stall}, 64'd1);
        @(negedge clk);
        start = 1'b0; is_store = ~st; size = ~sz; addr = rnd64(); wdata = rnd64();
`ifdef MISALIGN_TRAP_EN
        if (m_misaligned(sz, a[2:0])) begin
            chk("trap_req", {63'd0, mem_req}, 64'd0);
            chk("trap_err", {63'd0, err}, 64'd1);
            chk("trap_stall", {63'd0, stall}, 64'd0);
            @(negedge clk);
            chk("trap_err_end", {63'd0, err}, 64'd0);
            return;
        end
`endif
        for (int k = 0; k < TO; k++) begin
            if (k > 0) @(negedge clk);
            chk("req", {63'd0, mem_req}, 64'd1);
            chk("stall_req", {63'd0, stall}, 64'd1);
            chk("no_pulse", {62'd0, done, err}, 64'd0);
            chk("be", {56'd0, mem_be}, {56'd0, m_be(sz, a[2:0])});
            if (k == 0) begin
                chk("addr", mem_addr, {a[63:3], 3'b000});
                chk("we", {63'd0, mem_we}, {63'd0, st});
                chk("wdata", mem_wdata, m_wdata(sz, a[2:0], wd));
                chk("rdata_hold", rdata, exp_rdata);
            end
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rd : rnd64();
            if (k == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = rnd64();
        chk("req_drop", {63'd0, mem_req}, 64'd0);
        chk("stall_end", {63'd0, stall}, 64'd0);
        if (acked) begin
            if (!st) exp_rdata = m_load(sz, a[2:0], un, rd);
            chk("done", {63'd0, done}, 64'd1);
            chk("err_on_done", {63'd0, err}, 64'd0);
        end else begin
            chk("err", {63'd0, err}, 64'd1);
            chk("done_on_err", {63'd0, done}, 64'd0);
        end
        chk("rdata", rdata, exp_rdata);
        if (poke_done && acked) begin
            start = 1'b1; addr = rnd64(); size = 2'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_req", {63'd0, mem_req}, 64'd0);
        chk("idle_pulse", {62'd0, done, err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr = 64'd0; wdata = 64'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
        exp_rdata = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {60'd0, mem_req, mem_we, done, err}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_be", {56'd0, mem_be}, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        reset = 1'b0;

        access(1'b0, 2'b00, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_80FF_0000, 2, 1'b0);
        chk("lb_value", rdata, 64'hFFFF_FFFF_FFFF_FF80);
        access(1'b0, 2'b10, 1'b1, 64'h2004, 64'd0, 64'h89AB_CDEF_0000_0000, 1, 1'b1);
        chk("lwu_value", rdata, 64'h0000_0000_89AB_CDEF);
        access(1'b1, 2'b01, 1'b0, 64'h10, 64'h1234_5678_9ABC_DEF0, rnd64(), 0, 1'b0);
        access(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, rnd64(), TO + 5, 1'b0);
        access(1'b0, 2'b11, 1'b0, 64'h48, 64'd0, 64'hDEAD_BEEF_0123_4567, TO - 1, 1'b0);
        access(1'b0, 2'b10, 1'b0, 64'h1002, 64'd0, 64'h0000_CAFE_F00D_0000, 0, 1'b0);

        // Reset on the second REQ cycle.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'b11; addr = 64'h80;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 64'd0;
        chk("mid_rst_req", {63'd0, mem_req}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall}, 64'd0);
        chk("mid_rst_pulse", {62'd0, done, err}, 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        access(1'b0, 2'b01, 1'b0, 64'h2006, 64'd0, 64'h8001_0000_0000_0000, 1, 1'b0);

        for (int t = 0; t < 300; t++) begin
            int ack_at;
            ack_at = ($urandom_range(0, 5) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1));
            access(1'($urandom), 2'($urandom), 1'($urandom), rnd64(), rnd64(), rnd64(),
                   ack_at, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                mem_ack = 1'b1; mem_rdata = rnd64();
                @(negedge clk);
                mem_ack = 1'b0;
                chk("stray_ack_rdata", rdata, exp_rdata);
                chk("stray_ack_done", {63'd0, done}, 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
